sar_search: RTL



---
 rtl/sar_pkg.sv | 14 +
 rtl/sar_search.sv | 108 ++++++++++
 2 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the successive-approximation searcher.
//   WIDTH_DEF : default operand width; a search takes WIDTH_DEF answers.
//   state_e   : FSM states of sar_search.
package sar_pkg;

  localparam int WIDTH_DEF = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/sar_search.sv
// sar_search: successive-approximation searcher. It recovers an unknown target
// by presenting WIDTH probes to an external less-than comparator and
// rebuilding the target MSB-first from the answers (lt = target < probe).
//
// Ports:
//   clk, rst_n   single rising-edge clock, asynchronous active-low reset
//   start        launch a search (sampled only when idle)
//   abort        cancel the search in progress; no done is produced
//   probe        trial value for the comparator (0 unless probing)
//   probe_valid  probe is presented and awaiting an answer
//   lt, lt_valid comparator answer and its qualifier
//   busy         a search is in progress (ISSUE or FINISH)
//   done         one-cycle pulse; result takes acc at the end of this cycle
//   result       last completed search value, held until the next completion
//
// Handshake: a probe is presented while probe_valid=1 and stays stable until
// an answer is accepted; an answer is accepted on a rising edge where
// probe_valid=1 and lt_valid=1. lt_valid while probe_valid=0 is ignored.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] probe,
  output logic             probe_valid,
  input  logic             lt,
  input  logic             lt_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] trial;

  // Trial value: bits already decided plus the bit under test.
  assign trial = acc_q | (WIDTH'(1) << bit_q);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    bit_d    = bit_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        // abort is meaningless here and deliberately not looked at.
        if (start) begin
          state_d = ISSUE;
          acc_d   = '0;
          bit_d   = BW'(WIDTH - 1);
        end
      end
      ISSUE: begin
        // abort beats a simultaneous answer; the answer is dropped.
        if (abort) begin
          state_d = IDLE;
        end else if (lt_valid) begin
          // Keep the tested bit only when target >= trial.
          acc_d = lt ? acc_q : trial;
          if (bit_q == '0) begin
            state_d = FINISH;
          end else begin
            bit_d = bit_q - BW'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!abort) begin
          result_d = acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      bit_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      bit_q    <= bit_d;
      result_q <= result_d;
    end
  end

  // Outputs are decoded from state; only abort may suppress done, so lt and
  // lt_valid never reach an output combinationally.
  assign probe_valid = (state_q == ISSUE);
  assign probe       = probe_valid ? trial : '0;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == FINISH) && !abort;
  assign result      = result_q;

endmodule
